// File: rtl/mem_access_unit.sv
// MEM stage: issues aligned loads/stores to a ready-handshake data memory and registers MEM/WB outputs.
// Latency 1 cycle for non-memory ops, >=2 for memory ops; stalls upstream while waiting, bus error after MAX_WAIT cycles.
module mem_access_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aluresult,
    input  logic [4:0]  rd,
    input  logic        MemRead,
    input  logic        MemtoReg,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic [31:0] mem_forwarded_rtdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] readdataout,
    output logic [31:0] aluresultout,
    output logic [4:0]  rdout,
    output logic        MemtoRegout,
    output logic        RegWriteout,
    output logic        mem_misalign,
    output logic        mem_buserr
);
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] readdata_q, readdata_d, alu_q, alu_d;
    logic [4:0]  rd_q, rd_d;
    logic        mtr_q, mtr_d, regw_q, regw_d;
    logic        misalign_q, misalign_d, buserr_q, buserr_d;
    logic        stall;
    logic        acc, aligned, timeout;

    always_comb begin
        acc        = MemRead | MemWrite;
        aligned    = (aluresult[1:0] == 2'b00);
        timeout    = (cnt_q == LAST_WAIT);
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        readdata_d = 32'h0;
        alu_d      = aluresult;
        rd_d       = rd;
        mtr_d      = 1'b0;
        regw_d     = 1'b0;
        misalign_d = 1'b0;
        buserr_d   = 1'b0;
        stall      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!acc) begin
                    mtr_d  = MemtoReg;
                    regw_d = RegWrite;
                end else if (!aligned) begin
                    misalign_d = 1'b1;
                end else begin
                    stall   = 1'b1;
                    state_d = ACCESS;
                    req_d   = 1'b1;
                    we_d    = MemWrite;
                    addr_d  = aluresult;
                    wdata_d = mem_forwarded_rtdata;
                    cnt_d   = 8'h0;
                end
            end
            ACCESS: begin
                // A completing handshake wins over a coincident timeout.
                if (dmem_ready) begin
                    mtr_d      = MemtoReg;
                    regw_d     = RegWrite;
                    readdata_d = MemWrite ? 32'h0 : dmem_rdata;
                    req_d      = 1'b0;
                    state_d    = IDLE;
                end else if (timeout) begin
                    req_d    = 1'b0;
                    buserr_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'h1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_stall = stall & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'h0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            readdata_q <= 32'h0;
            alu_q      <= 32'h0;
            rd_q       <= 5'h0;
            mtr_q      <= 1'b0;
            regw_q     <= 1'b0;
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            readdata_q <= readdata_d;
            alu_q      <= alu_d;
            rd_q       <= rd_d;
            mtr_q      <= mtr_d;
            regw_q     <= regw_d;
            misalign_q <= misalign_d;
            buserr_q   <= buserr_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign readdataout  = readdata_q;
    assign aluresultout = alu_q;
    assign rdout        = rd_q;
    assign MemtoRegout  = mtr_q;
    assign RegWriteout  = regw_q;
    assign mem_misalign = misalign_q;
    assign mem_buserr   = buserr_q;
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 15: ready-wait cycles allowed before a bus error (range 2..255).
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- aluresult  in  32  EX/MEM ALU result, used as byte address
- rd  in  5  destination register
- MemRead, MemtoReg, MemWrite, RegWrite  in  1 each  EX/MEM control bits
- mem_forwarded_rtdata  in  32  store data
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address (byte address, low 2 bits zero)
- dmem_wdata  out  32  store data
- dmem_ready  in  1  memory accepts or completes the access
- dmem_rdata  in  32  load data, valid while dmem_ready = 1
- mem_stall  out  1  freeze the upstream pipeline; EX/MEM holds its outputs
- readdataout  out  32  MEM/WB load data
- aluresultout  out  32  MEM/WB ALU result
- rdout  out  5  MEM/WB destination register
- MemtoRegout, RegWriteout  out  1 each  MEM/WB controls
- mem_misalign  out  1  one-cycle pulse: misaligned access dropped
- mem_buserr  out  1  one-cycle pulse: access timed out

Function
REQ-003 The block SHALL use a two-state FSM, IDLE and ACCESS, with an 8-bit wait counter.
REQ-004 An access SHALL be defined as acc = MemRead | MemWrite. When both are set, the access SHALL be a write.
REQ-005 In IDLE with acc = 0, the block SHALL register its inputs into the MEM/WB outputs at the next edge, set readdataout to 0, and keep mem_stall = 0.
REQ-006 In IDLE with acc = 1 and aluresult[1:0] != 0:
- no request is issued and mem_stall = 0;
- at the next edge, the MEM/WB outputs take a bubble (RegWriteout = 0, MemtoRegout = 0) and mem_misalign pulses for 1 cycle.
REQ-007 In IDLE with acc = 1 and the address aligned:
- mem_stall = 1 combinationally;
- at the next edge, the state becomes ACCESS, dmem_req = 1, dmem_we, dmem_addr and dmem_wdata are latched, and the counter clears;
- the MEM/WB outputs take a bubble.
REQ-008 In ACCESS, dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL be held stable until exit.
REQ-009 In ACCESS with dmem_ready = 0, mem_stall SHALL be 1, the counter SHALL increment, and the MEM/WB outputs SHALL take a bubble.
REQ-010 In ACCESS with dmem_ready = 1:
- mem_stall = 0 in that cycle;
- at the next edge, the MEM/WB outputs register the current inputs, readdataout = dmem_rdata for a read (0 for a write), dmem_req drops and the state returns to IDLE.
REQ-011 When the counter reaches MAX_WAIT-1 with dmem_ready = 0:
- mem_stall = 0 in that cycle;
- at the next edge, dmem_req drops, the state returns to IDLE, mem_buserr pulses for 1 cycle and the MEM/WB outputs take a bubble.
REQ-012 dmem_ready SHALL be ignored in IDLE, and dmem_rdata SHALL be ignored when dmem_ready = 0.
REQ-013 Minimum memory-access latency SHALL be 2 cycles (one stall cycle); non-memory instructions SHALL take 1 cycle.
REQ-014 After each REQ-010 or REQ-011 exit, the block SHALL spend 1 cycle in IDLE evaluating the new upstream values before any new request.
REQ-015 mem_stall SHALL be combinational from state, acc, aluresult[1:0], dmem_ready and the counter; all other outputs SHALL be registered.

Reset
REQ-016 With reset = 1 at a rising edge, the block SHALL set:
- state IDLE and counter 0;
- every registered output to 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, readdataout, aluresultout, rdout, MemtoRegout, RegWriteout, mem_misalign, mem_buserr).
REQ-017 Reset during ACCESS SHALL abort the access: dmem_req = 0 after that edge, and no bus-error or misalign pulse is produced.
REQ-018 While reset = 1, mem_stall SHALL be 0.

Verification
REQ-019 ALU pass-through: aluresult = 0x1234, rd = 5, RegWrite = 1, no memory access -> next cycle aluresultout = 0x1234, rdout = 5, RegWriteout = 1, mem_stall never 1.
REQ-020 Load with 3-cycle wait: MemRead = 1, aluresult = 0x40, dmem_ready high in the 3rd ACCESS cycle with rdata = 0xDEADBEEF -> dmem_addr = 0x40, mem_stall high for 3 cycles, then readdataout = 0xDEADBEEF and RegWriteout = 1.
REQ-021 Store: MemWrite = 1, aluresult = 0x80, rtdata = 0xA5A5A5A5, dmem_ready on the first ACCESS cycle -> dmem_we = 1, dmem_wdata = 0xA5A5A5A5, exactly 1 stall cycle, RegWriteout = 0.
REQ-022 Misaligned access: MemRead = 1, aluresult = 0x42 -> dmem_req stays 0, mem_misalign pulses once, RegWriteout = 0, no stall.
REQ-023 Timeout: MemRead = 1 with dmem_ready held 0 and MAX_WAIT = 4 -> mem_stall high for 4 cycles, then mem_buserr pulses once, dmem_req = 0, state IDLE.
REQ-024 Mid-access reset: reset asserted in the 2nd ACCESS cycle -> all outputs 0 at the next edge; a following load completes normally.
